// File: rtl/ex_issue_stage.sv
// ID/EX register: decodes ALU control and operand B for one held instruction; optional EX_FWD_EN adds EX/MEM forwarding.
// Latency 1 cycle; in_ready = !out_valid | out_ready, outputs frozen while stalled, flush discards held and incoming.
module ex_issue_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_alu_op,
   input  logic [5:0]       in_funct,
   input  logic [4:0]       in_rs_addr,
   input  logic [4:0]       in_rt_addr,
   input  logic [DW-1:0]    in_rs_data,
   input  logic [DW-1:0]    in_rt_data,
   input  logic [15:0]      in_imm,
   input  logic             in_alu_src,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic             flush,
`ifdef EX_FWD_EN
   input  logic             fwd_we,
   input  logic [4:0]       fwd_rd,
   input  logic [DW-1:0]    fwd_data,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       alu_ctl,
   output logic [DW-1:0]    alu_a,
   output logic [DW-1:0]    alu_b,
   output logic [4:0]       out_rd,
   output logic             out_reg_write,
   output logic             illegal,
   output logic [CNT_W-1:0] stall_cnt
);

   logic          load;
   logic [2:0]    dec_ctl;
   logic          dec_illegal;
   logic [DW-1:0] rs_val;
   logic [DW-1:0] rt_val;
   logic [DW-1:0] dec_b;
   logic [DW-1:0] imm_sext;
   logic [DW-1:0] imm_zext;

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;
   assign imm_sext = {{(DW-16){in_imm[15]}}, in_imm};
   assign imm_zext = {{(DW-16){1'b0}}, in_imm};

`ifdef EX_FWD_EN
   // Register 0 is hardwired, so a pending write to it must never be forwarded.
   assign rs_val = (fwd_we && fwd_rd != 5'd0 && fwd_rd == in_rs_addr) ? fwd_data : in_rs_data;
   assign rt_val = (fwd_we && fwd_rd != 5'd0 && fwd_rd == in_rt_addr) ? fwd_data : in_rt_data;
`else
   logic unused_addr;
   assign unused_addr = ^{in_rs_addr, in_rt_addr};
   assign rs_val = in_rs_data;
   assign rt_val = in_rt_data;
`endif

   always_comb begin
      dec_ctl     = 3'b010;
      dec_illegal = 1'b0;
      case (in_alu_op)
         2'b00: dec_ctl = 3'b010;
         2'b01: dec_ctl = 3'b110;
         2'b11: dec_ctl = 3'b001;
         default: begin
            case (in_funct)
               6'b100000: dec_ctl = 3'b010;
               6'b100010: dec_ctl = 3'b110;
               6'b100100: dec_ctl = 3'b000;
               6'b100101: dec_ctl = 3'b001;
               6'b101010: dec_ctl = 3'b111;
               default:   dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   // ori always zero-extends, independent of alu_src.
   always_comb begin
      dec_b = rt_val;
      if (in_alu_op == 2'b11) begin
         dec_b = imm_zext;
      end else if (in_alu_src) begin
         dec_b = imm_sext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         alu_ctl       <= 3'b010;
         alu_a         <= '0;
         alu_b         <= '0;
         out_rd        <= 5'd0;
         out_reg_write <= 1'b0;
         illegal       <= 1'b0;
         stall_cnt     <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
         end else if (load) begin
            out_valid     <= 1'b1;
            alu_ctl       <= dec_ctl;
            alu_a         <= rs_val;
            alu_b         <= dec_b;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write && !dec_illegal;
            illegal       <= dec_illegal;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_issue_stage;
   localparam int DW    = 32;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;
   localparam int VW    = 2 + 3 + DW + DW + 5 + 1 + 1 + CNT_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, in_valid, in_ready, in_alu_src, in_reg_write, flush;
   logic [1:0]       in_alu_op;
   logic [5:0]       in_funct;
   logic [4:0]       in_rs_addr, in_rt_addr, in_rd;
   logic [DW-1:0]    in_rs_data, in_rt_data;
   logic [15:0]      in_imm;
   logic             out_valid, out_ready, out_reg_write, illegal;
   logic [2:0]       alu_ctl;
   logic [DW-1:0]    alu_a, alu_b;
   logic [4:0]       out_rd;
   logic [CNT_W-1:0] stall_cnt;
`ifdef EX_FWD_EN
   logic             fwd_we;
   logic [4:0]       fwd_rd;
   logic [DW-1:0]    fwd_data;
`endif

   ex_issue_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_funct(in_funct), .in_rs_addr(in_rs_addr),
      .in_rt_addr(in_rt_addr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_alu_src(in_alu_src), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .flush(flush),
`ifdef EX_FWD_EN
      .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
      .alu_a(alu_a), .alu_b(alu_b), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .illegal(illegal), .stall_cnt(stall_cnt)
   );

   int checks = 0;
   int passed = 0;

   // Behavioural model of the held instruction.
   bit            m_valid;
   logic [2:0]    m_ctl;
   logic [DW-1:0] m_a, m_b;
   logic [4:0]    m_rd;
   bit            m_rw, m_ill;
   int            m_cnt;

   function automatic logic [VW-1:0] got_vec();
      return {in_ready, out_valid, alu_ctl, alu_a, alu_b, out_rd, out_reg_write, illegal, stall_cnt};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic rdy;
      rdy = !m_valid || out_ready;
      return {rdy, m_valid, m_ctl, m_a, m_b, m_rd, m_rw, m_ill, CNT_W'(m_cnt)};
   endfunction

   task automatic model_load();
      int ctl;
      bit ill;
      logic [DW-1:0] rs, rt;
      ill = 0;
      ctl = 2;
      rs  = in_rs_data;
      rt  = in_rt_data;
`ifdef EX_FWD_EN
      if (fwd_we && fwd_rd != 0 && fwd_rd == in_rs_addr) rs = fwd_data;
      if (fwd_we && fwd_rd != 0 && fwd_rd == in_rt_addr) rt = fwd_data;
`endif
      case (in_alu_op)
         2'd0: ctl = 2;
         2'd1: ctl = 6;
         2'd3: ctl = 1;
         default: begin
            if      (in_funct == 6'd32) ctl = 2;
            else if (in_funct == 6'd34) ctl = 6;
            else if (in_funct == 6'd36) ctl = 0;
            else if (in_funct == 6'd37) ctl = 1;
            else if (in_funct == 6'd42) ctl = 7;
            else begin ctl = 2; ill = 1; end
         end
      endcase
      m_valid = 1;
      m_ctl   = 3'(ctl);
      m_a     = rs;
      if (in_alu_op == 2'd3) m_b = {16'h0000, in_imm};
      else if (in_alu_src)   m_b = {{16{in_imm[15]}}, in_imm};
      else                   m_b = rt;
      m_rd  = in_rd;
      m_rw  = in_reg_write && !ill;
      m_ill = ill;
   endtask

   // Advance model and DUT by one clock; leaves time at posedge+1.
   task automatic cycle();
      bit acc;
      if (rst) begin
         m_valid = 0; m_ctl = 3'b010; m_a = '0; m_b = '0;
         m_rd = '0; m_rw = 0; m_ill = 0; m_cnt = 0;
      end else begin
         acc = in_valid && (!m_valid || out_ready);
         if (m_valid && !out_ready) m_cnt = (m_cnt >= SAT) ? SAT : m_cnt + 1;
         if (flush) begin
            m_valid = 0;
            m_rw    = 0;
         end else if (acc) begin
            model_load();
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; in_valid = 0; in_alu_op = 0; in_funct = 0; in_rs_addr = 0;
      in_rt_addr = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
      in_alu_src = 0; in_rd = 0; in_reg_write = 0; flush = 0; out_ready = 1;
`ifdef EX_FWD_EN
      fwd_we = 0; fwd_rd = 0; fwd_data = 0;
`endif
   endtask

   task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
                            input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                            input logic [15:0] imm, input logic src,
                            input logic [4:0] rd, input logic rw);
      in_valid = 1; in_alu_op = op; in_funct = fn; in_rs_data = rs; in_rt_data = rt;
      in_imm = imm; in_alu_src = src; in_rd = rd; in_reg_write = rw;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1; in_valid = 1; out_ready = 0; flush = 1;
      in_alu_op = 2'b10; in_funct = 6'b100010; in_rs_data = 32'h55; in_reg_write = 1;
      cycle();
      cycle();
      checks++;
      if ({out_valid, alu_ctl, stall_cnt, in_ready, alu_a, alu_b, out_rd, out_reg_write, illegal} !==
          {1'b0, 3'b010, CNT_W'(0), 1'b1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0})
         $display("FAIL reset: got v=%b ctl=%b cnt=%0d rdy=%b a=%h b=%h, expected v=0 ctl=010 cnt=0 rdy=1 a=0 b=0",
                  out_valid, alu_ctl, stall_cnt, in_ready, alu_a, alu_b);
      else passed++;
      idle();
   endtask

   task automatic test_rtype_sub();
      do_reset();
      set_instr(2'b10, 6'b100010, 32'd7, 32'd3, 16'h0, 1'b0, 5'd9, 1'b1);
      cycle();
      checks++;
      if ({out_valid, alu_ctl, alu_a, alu_b, out_rd, out_reg_write} !==
          {1'b1, 3'b110, 32'd7, 32'd3, 5'd9, 1'b1})
         $display("FAIL rtype_sub: got v=%b ctl=%b a=%h b=%h rd=%0d we=%b, expected 1 110 7 3 9 1",
                  out_valid, alu_ctl, alu_a, alu_b, out_rd, out_reg_write);
      else passed++;
      idle();
      cycle();
      checks++;
      if ({out_valid, alu_a} !== {1'b0, 32'd7})
         $display("FAIL drain_hold: got v=%b a=%h, expected v=0 a=7", out_valid, alu_a);
      else passed++;
   endtask

   task automatic test_imm();
      do_reset();
      set_instr(2'b00, 6'h3f, 32'h100, 32'h1234, 16'hFFFC, 1'b1, 5'd4, 1'b1);
      cycle();
      checks++;
      if ({alu_ctl, alu_b} !== {3'b010, 32'hFFFFFFFC})
         $display("FAIL lw_sext: got ctl=%b b=%h, expected 010 FFFFFFFC", alu_ctl, alu_b);
      else passed++;
      set_instr(2'b11, 6'h00, 32'h100, 32'h1234, 16'h8001, 1'b0, 5'd5, 1'b1);
      cycle();
      checks++;
      if ({alu_ctl, alu_b, illegal} !== {3'b001, 32'h00008001, 1'b0})
         $display("FAIL ori_zext: got ctl=%b b=%h ill=%b, expected 001 00008001 0", alu_ctl, alu_b, illegal);
      else passed++;
      idle();
   endtask

   task automatic test_backpressure();
      do_reset();
      set_instr(2'b00, 6'h0, 32'hA1, 32'hA2, 16'h0, 1'b0, 5'd1, 1'b1);
      cycle();
      set_instr(2'b01, 6'h0, 32'hB1, 32'hB2, 16'h0, 1'b0, 5'd2, 1'b1);
      out_ready = 0;
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, expected 0", in_ready);
      else passed++;
      for (int i = 0; i < 5; i++) cycle();
      checks++;
      if ({out_valid, alu_ctl, alu_a, out_rd, stall_cnt, in_ready} !==
          {1'b1, 3'b010, 32'hA1, 5'd1, CNT_W'(5), 1'b0})
         $display("FAIL bp_frozen: got v=%b ctl=%b a=%h rd=%0d cnt=%0d rdy=%b, expected 1 010 a1 1 5 0",
                  out_valid, alu_ctl, alu_a, out_rd, stall_cnt, in_ready);
      else passed++;
      out_ready = 1;
      cycle();
      checks++;
      if ({out_valid, alu_ctl, alu_a, alu_b, out_rd, stall_cnt} !==
          {1'b1, 3'b110, 32'hB1, 32'hB2, 5'd2, CNT_W'(5)})
         $display("FAIL bp_second_load: got v=%b ctl=%b a=%h b=%h rd=%0d cnt=%0d, expected 1 110 b1 b2 2 5",
                  out_valid, alu_ctl, alu_a, alu_b, out_rd, stall_cnt);
      else passed++;
      idle();
      out_ready = 0;
      in_valid = 0;
      for (int i = 0; i < 20; i++) cycle();
      checks++;
      if (stall_cnt !== CNT_W'(SAT))
         $display("FAIL stall_saturate: got %0d, expected %0d", stall_cnt, SAT);
      else passed++;
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      set_instr(2'b10, 6'b100101, 32'hC1, 32'hC2, 16'h0, 1'b0, 5'd3, 1'b1);
      cycle();
      out_ready = 0;
      cycle();
      set_instr(2'b10, 6'b101010, 32'hD1, 32'hD2, 16'h0, 1'b0, 5'd6, 1'b1);
      flush = 1;
      cycle();
      checks++;
      if ({out_valid, in_ready, out_reg_write} !== 3'b010)
         $display("FAIL flush_clear: got v=%b rdy=%b we=%b, expected 0 1 0", out_valid, in_ready, out_reg_write);
      else passed++;
      idle();
      cycle();
      checks++;
      if ({out_valid, alu_a, alu_ctl} !== {1'b0, 32'hC1, 3'b001})
         $display("FAIL flush_discard: got v=%b a=%h ctl=%b, expected 0 c1 001", out_valid, alu_a, alu_ctl);
      else passed++;
   endtask

   task automatic test_illegal();
      do_reset();
      set_instr(2'b10, 6'b000000, 32'h11, 32'h22, 16'h0, 1'b0, 5'd8, 1'b1);
      cycle();
      checks++;
      if ({out_valid, illegal, out_reg_write, alu_ctl} !== {1'b1, 1'b1, 1'b0, 3'b010})
         $display("FAIL illegal_funct: got v=%b ill=%b we=%b ctl=%b, expected 1 1 0 010",
                  out_valid, illegal, out_reg_write, alu_ctl);
      else passed++;
      idle();
   endtask

`ifdef EX_FWD_EN
   task automatic test_fwd();
      do_reset();
      set_instr(2'b10, 6'b100000, 32'h1111, 32'h2222, 16'h0, 1'b0, 5'd7, 1'b1);
      in_rs_addr = 5; in_rt_addr = 6;
      fwd_we = 1; fwd_rd = 5; fwd_data = 32'hDEAD;
      cycle();
      checks++;
      if ({alu_a, alu_b} !== {32'hDEAD, 32'h2222})
         $display("FAIL fwd_rs: got a=%h b=%h, expected DEAD 2222", alu_a, alu_b);
      else passed++;
      in_rs_addr = 0; fwd_rd = 0;
      cycle();
      checks++;
      if (alu_a !== 32'h1111) $display("FAIL fwd_r0: got a=%h, expected 1111", alu_a);
      else passed++;
      idle();
   endtask
`endif

   task automatic test_random();
      logic [5:0] legal [5];
      logic [VW-1:0] g, e;
      legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 60) == 0);
         in_valid     = $urandom_range(0, 3) != 0;
         in_alu_op    = 2'($urandom);
         in_funct     = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 6'($urandom);
         in_rs_addr   = 5'($urandom_range(0, 7));
         in_rt_addr   = 5'($urandom_range(0, 7));
         in_rs_data   = $urandom;
         in_rt_data   = $urandom;
         in_imm       = 16'($urandom);
         in_alu_src   = 1'($urandom);
         in_rd        = 5'($urandom);
         in_reg_write = 1'($urandom);
         flush        = ($urandom_range(0, 9) == 0);
         out_ready    = $urandom_range(0, 2) != 0;
`ifdef EX_FWD_EN
         fwd_we   = 1'($urandom);
         fwd_rd   = 5'($urandom_range(0, 7));
         fwd_data = $urandom;
`endif
         cycle();
         #1;
         g = got_vec();
         e = exp_vec();
         checks++;
         if (g !== e) $display("FAIL random[%0d]: got %h, expected %h", i, g, e);
         else passed++;
      end
      idle();
   endtask

   initial begin
      idle();
      m_valid = 0; m_ctl = 3'b010; m_a = '0; m_b = '0; m_rd = '0; m_rw = 0; m_ill = 0; m_cnt = 0;
      test_reset();
      test_rtype_sub();
      test_imm();
      test_backpressure();
      test_flush();
      test_illegal();
`ifdef EX_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
